cpu_io_port: RTL
================

# cpu_io_port

Peripheral-side endpoint for the CPU's data input/output ports. It buffers words the CPU writes out and supplies words the CPU reads in. A host (testbench, switches or a display driver) fills and drains the block through two small FIFOs. The block sits beside `memory`, on the far side of the CPU's `in`/`out` buses, and runs on the shared CPU clock.

## Interface
- `DATA_WIDTH`, 16, width of every data word.
- `DEPTH`, 4, entries per FIFO; must be a power of two, at least 2.
- `CW`, `$clog2(DEPTH)+1`, derived width of the count outputs; not overridden.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `out_vld` in 1: CPU presents `out_data` this cycle.
- `out_data` in DATA_WIDTH: CPU output word.
- `out_rdy` out 1: output FIFO not full.
- `in_req` in 1: CPU requests one input word.
- `in_data` out DATA_WIDTH: word delivered to the CPU; holds its value between deliveries.
- `in_vld` out 1: one-cycle pulse marking a delivery on `in_data`.
- `host_wr` in 1: push `host_wdata` into the input FIFO.
- `host_wdata` in DATA_WIDTH: host word destined for the CPU.
- `host_full` out 1: input FIFO full.
- `host_rd` in 1: pop the output FIFO head.
- `host_rdata` out DATA_WIDTH: output FIFO head, first-word-fall-through.
- `host_empty` out 1: output FIFO empty.
- `in_count` out CW: input FIFO occupancy.
- `out_count` out CW: output FIFO occupancy.
- `ovf` out 1: sticky; set when any push is dropped.

## Operation
- **Two independent circular FIFOs**
  - Each has read/write pointers of width `CW`.
  - The MSB distinguishes full from empty; pointers wrap modulo `2*DEPTH`.
- **Output path**
  - `out_vld` with `out_rdy=1` pushes `out_data`.
  - `out_vld` while full drops the word and sets `ovf`. A same-cycle `host_rd` does not rescue the push.
  - `host_rd` with `host_empty=0` pops. `host_rd` on empty is ignored.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
- **Input path**
  - `host_wr` with `host_full=0` pushes. `host_wr` while full drops the word and sets `ovf`.
- **Delivery state machine**
  - States are `IDLE` and `WAIT`.
  - IDLE, `in_req=1`, input FIFO non-empty: pop the FIFO, load `in_data`, pulse `in_vld`, stay in IDLE.
  - IDLE, `in_req=1`, input FIFO empty: go to WAIT.
  - WAIT, input FIFO non-empty: pop, load, pulse, return to IDLE.
  - `in_req` is ignored while in WAIT.
  - There is no bypass: a word written into an empty FIFO is delivered at the earliest on the following edge.
  - A `host_wr` and a delivery pop in the same cycle both take effect.
- **Clearing `ovf`**: only reset clears it.

## Timing
- **Reset values**
  - State IDLE, both FIFOs empty, `in_count=out_count=0`.
  - `in_data=0`, `in_vld=0`, `ovf=0`.
  - `out_rdy=1`, `host_full=0`, `host_empty=1`.
  - `host_rdata` equals the RAM content at entry 0; it is don't-care while `host_empty=1`.
- **Reset during WAIT** aborts the pending request; no delivery follows.
- **Registered outputs**: `in_data`, `in_vld`, `ovf`, the pointers and the state update on the edge.
- **Combinational outputs**: `out_rdy`, `host_full`, `host_empty`, the counts and `host_rdata` derive from the pointers.
- **Read latency with data present**: `in_req` sampled high at edge N gives `in_vld=1` and valid `in_data` for the cycle after edge N, and `in_count` drops by 1 at edge N.
- **Read latency from empty**: `host_wr` at edge M (FSM in WAIT) gives the pop at edge M+1 and `in_vld` high for the cycle after M+1.
- **Back-to-back reads**: `in_req` held high in IDLE with data present pops every cycle, giving consecutive `in_vld` pulses.
- **Output latency**: a pushed word is visible on `host_rdata` in the cycle after the pushing edge when the FIFO was empty.

## Test plan
- **Reset**: assert `rst_n=0` mid-cycle with both FIFOs half full. Required: all outputs immediately at reset values, `in_count=out_count=0`, `ovf=0`.
- **CPU-to-host**:
  - CPU pushes 0x0001..0x0004 on consecutive cycles. Required: `out_count=4`, `out_rdy=0`.
  - A fifth push of 0x0005. Required: dropped, `ovf=1`.
  - Host then pops 4 times. Required: reads 1, 2, 3, 4 in order, then `host_empty=1`.
- **Host-to-CPU, data present**: host writes 0x0009, then `in_req` for one cycle. Required: `in_vld` pulses once one cycle later with `in_data=0x0009`, then `in_count=0`.
- **Host-to-CPU, FIFO empty**: `in_req` with the FIFO empty; wait 5 cycles; host writes 0xBEEF. Required: `in_vld` stays 0 throughout the wait, then pulses exactly once, two cycles after the write edge, with `in_data=0xBEEF`.
- **Pointer wrap**: 10 push/pop pairs through each FIFO using distinct values, including simultaneous push and pop at count 1. Required: data order preserved, counts correct at every cycle, no spurious `ovf`.
- **Simultaneous full**: output FIFO full, `out_vld` and `host_rd` in the same cycle. Required: pop succeeds, push dropped, `out_count=3`, `ovf=1`.

Source files
------------

// File: rtl/cpu_io_port.sv
// Peripheral endpoint: buffers CPU output words for the host, feeds host words to the CPU on request.
// Latency: in_req with data present -> in_vld next cycle; from empty, one edge after the host write lands.
// Backpressure: out_rdy/host_full report FIFO full; a push while full is dropped and latches ovf.

// Generic circular FIFO with first-word-fall-through head and drop reporting.
// Latency: a pushed word reaches rdata on the cycle after the pushing edge.
// Backpressure: full blocks pushes (reported on drop); pop on empty is ignored.
module io_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  ram [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign drop    = push && full;
  assign rdata   = ram[rd_ptr[AW-1:0]];

  // Storage is not reset; its content is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) ram[wr_ptr[AW-1:0]] <= wdata;
  end

  // Advance pointers on accepted push/pop; they wrap modulo 2*DEPTH naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

module cpu_io_port #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  out_vld,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_rdy,
  input  logic                  in_req,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_vld,
  input  logic                  host_wr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_full,
  input  logic                  host_rd,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_empty,
  output logic [CW-1:0]         in_count,
  output logic [CW-1:0]         out_count,
  output logic                  ovf
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  in_pop;
  logic                  in_empty;
  logic [DATA_WIDTH-1:0] in_head;
  logic                  out_full;
  logic                  in_drop;
  logic                  out_drop;

  // CPU -> host: a same-cycle host pop does not free space for a push into a full FIFO.
  io_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH), .CW(CW)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (out_vld),
    .wdata (out_data),
    .pop   (host_rd),
    .rdata (host_rdata),
    .count (out_count),
    .full  (out_full),
    .empty (host_empty),
    .drop  (out_drop)
  );

  // Host -> CPU: drained only by the delivery state machine.
  io_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH), .CW(CW)) u_in_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (host_wr),
    .wdata (host_wdata),
    .pop   (in_pop),
    .rdata (in_head),
    .count (in_count),
    .full  (host_full),
    .empty (in_empty),
    .drop  (in_drop)
  );

  assign out_rdy = !out_full;

  // Delivery FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Decide whether to pop this cycle; empty comes from registered pointers, so there is no bypass.
  always_comb begin
    state_nxt = state;
    in_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (in_req) begin
          if (!in_empty) in_pop    = 1'b1;
          else           state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!in_empty) begin
          in_pop    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register the delivered word and its one-cycle strobe; in_data holds between deliveries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_data <= '0;
      in_vld  <= 1'b0;
    end else begin
      in_vld <= in_pop;
      if (in_pop) in_data <= in_head;
    end
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   ovf <= 1'b0;
    else if (in_drop || out_drop) ovf <= 1'b1;
  end

endmodule
